// File: rtl/rev_pe_seq_ctrl.sv
// Job sequencer for the reversible multiply-add PE: issues reads, tracks tokens, strobes write-back.
// Read in cycle k gives write-back in cycle k+PIPE_LAT; no backpressure, abort flushes the in-flight tokens.
module rev_pe_seq_ctrl #(
  parameter int DATA_NUM  = 16,
  parameter int ADDR_W    = $clog2(DATA_NUM),
  parameter int PIPE_LAT  = 3,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W:0]      len,
  input  logic                 err1_in,
  input  logic                 err2_in,
  output logic                 rd_en,
  output logic [ADDR_W-1:0]    rd_addr,
  output logic                 pe_en,
  output logic                 wb_en,
  output logic [ADDR_W-1:0]    wb_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 host_rd_ok,
  output logic                 aborted,
  output logic [ERR_CNT_W-1:0] err_cnt1,
  output logic [ERR_CNT_W-1:0] err_cnt2
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   issue_cnt;
  logic [ADDR_W-1:0]   wb_cnt;
  logic [ADDR_W-1:0]   last_idx;
  logic [PIPE_LAT-1:0] tok;
  logic [ADDR_W:0]     len_clip;

  assign len_clip = (len > (ADDR_W+1)'(DATA_NUM)) ? (ADDR_W+1)'(DATA_NUM) : len;

  // Every output is a decode of a flop, so reset reaches the pins without a clock.
  assign rd_en      = (state == RUN);
  assign rd_addr    = issue_cnt;
  assign busy       = (state == RUN) || (state == DRAIN);
  assign pe_en      = busy;
  assign done       = (state == DONE);
  assign host_rd_ok = (state == IDLE);
  assign wb_en      = tok[PIPE_LAT-1];
  assign wb_addr    = wb_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      issue_cnt <= '0;
      wb_cnt    <= '0;
      last_idx  <= '0;
      tok       <= '0;
      aborted   <= 1'b0;
      err_cnt1  <= '0;
      err_cnt2  <= '0;
    end else begin
      tok <= (tok << 1) | PIPE_LAT'(rd_en);
      if (busy && err1_in && (err_cnt1 != '1)) err_cnt1 <= err_cnt1 + 1'b1;
      if (busy && err2_in && (err_cnt2 != '1)) err_cnt2 <= err_cnt2 + 1'b1;
      if (wb_en) wb_cnt <= wb_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (start && !abort && (len != '0)) begin
            state     <= RUN;
            last_idx  <= ADDR_W'(len_clip - 1'b1);
            issue_cnt <= '0;
            wb_cnt    <= '0;
            err_cnt1  <= '0;
            err_cnt2  <= '0;
            aborted   <= 1'b0;
          end
        end
        RUN: begin
          issue_cnt <= issue_cnt + 1'b1;
          if (issue_cnt == last_idx) state <= DRAIN;
        end
        DRAIN: begin
          if (wb_en && (wb_cnt == last_idx)) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase

      // Abort overrides whatever transition the case above chose this cycle.
      if (abort && (state != IDLE)) begin
        state     <= IDLE;
        tok       <= '0;
        issue_cnt <= '0;
        wb_cnt    <= '0;
        aborted   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rev_pe_seq_ctrl.sv
// Bench for rev_pe_seq_ctrl: directed jobs push expected read/write-back/done events into queues,
// and a monitor pops and compares each one as the DUT strobes it.
module tb_rev_pe_seq_ctrl;

  localparam int DN    = 16;
  localparam int AW    = 4;
  localparam int PL    = 3;
  // A 16-entry job keeps pe_en high for at most 19 cycles, so a 4-bit counter is what can saturate.
  localparam int ERR_W = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start, abort, err1_in, err2_in;
  logic [AW:0]     len;
  logic            rd_en, pe_en, wb_en, busy, done, host_rd_ok, aborted;
  logic [AW-1:0]   rd_addr, wb_addr;
  logic [ERR_W-1:0] err_cnt1, err_cnt2;

  rev_pe_seq_ctrl #(.DATA_NUM(DN), .ADDR_W(AW), .PIPE_LAT(PL), .ERR_CNT_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
    .err1_in(err1_in), .err2_in(err2_in), .rd_en(rd_en), .rd_addr(rd_addr),
    .pe_en(pe_en), .wb_en(wb_en), .wb_addr(wb_addr), .busy(busy), .done(done),
    .host_rd_ok(host_rd_ok), .aborted(aborted), .err_cnt1(err_cnt1), .err_cnt2(err_cnt2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_q[$];
  int wb_q[$];
  int done_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Event keys: cycle*256 + address for reads/write-backs, cycle for done.
  task automatic push_job(input int t0, input int n, input int n_rd, input int n_wb, input bit dn);
    for (int i = 0; i < n_rd; i++) rd_q.push_back((t0 + 1 + i) * 256 + i);
    for (int i = 0; i < n_wb; i++) wb_q.push_back((t0 + 1 + PL + i) * 256 + i);
    if (dn) done_q.push_back(t0 + n + PL + 1);
  endtask

  always @(negedge clk) begin : monitor
    int e;
    if (rst_n === 1'b1) begin
      if (rd_en) begin
        e = (rd_q.size() != 0) ? rd_q.pop_front() : -1;
        chk("rd_event", cyc * 256 + int'(rd_addr), e);
      end
      if (wb_en) begin
        e = (wb_q.size() != 0) ? wb_q.pop_front() : -1;
        chk("wb_event", cyc * 256 + int'(wb_addr), e);
      end
      if (done) begin
        e = (done_q.size() != 0) ? done_q.pop_front() : -1;
        chk("done_event", cyc, e);
      end
    end
  end

  task automatic do_start(input int l, output int t0);
    @(negedge clk);
    start = 1'b1;
    len   = (AW+1)'(l);
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    while (!host_rd_ok && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!host_rd_ok) chk("idle_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; len = '0; err1_in = 1'b0; err2_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {rd_en, wb_en, pe_en, busy, done, aborted, host_rd_ok}, 7'b0000001);
    chk("reset_err", {err_cnt1, err_cnt2}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: len=4 basic job with status timeline
    do_start(4, t0);
    push_job(t0, 4, 4, 4, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      bit b, h;
      wait_until(t0 + c);
      b = (c <= 7);
      h = !(c <= 8);
      chk("t1_status", {busy, pe_en, host_rd_ok}, {b, b, h});
    end
    wait_idle();

    // 2: len=0 is ignored, len=20 clips to 16
    do_start(0, t0);
    repeat (4) @(negedge clk);
    chk("t2_len0_idle", {host_rd_ok, busy}, 2'b10);
    do_start(20, t0);
    push_job(t0, 16, 16, 16, 1'b1);
    wait_idle();

    // 3: err1 saturates over a long job; next start clears it; err2 counts alone
    err1_in = 1'b1;
    do_start(16, t0);
    push_job(t0, 16, 16, 16, 1'b1);
    wait_idle();
    err1_in = 1'b0;
    chk("t3_err1_sat", err_cnt1, 15);
    chk("t3_err2_zero", err_cnt2, 0);
    err2_in = 1'b1;
    do_start(2, t0);
    push_job(t0, 2, 2, 2, 1'b1);
    chk("t3_err1_cleared", err_cnt1, 0);
    wait_idle();
    repeat (3) @(negedge clk);
    err2_in = 1'b0;
    chk("t3_err2_count", err_cnt2, 5);
    chk("t3_err1_hold", err_cnt1, 0);

    // 4: abort in second DRAIN cycle; write-back at that cycle still lands, nothing after
    do_start(4, t0);
    push_job(t0, 4, 4, 3, 1'b0);
    wait_until(t0 + 6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_after_abort", {host_rd_ok, busy, aborted, done}, 4'b1010);
    repeat (6) @(negedge clk);
    do_start(1, t0);
    push_job(t0, 1, 1, 1, 1'b1);
    chk("t4_aborted_clr", {aborted, busy}, 2'b01);
    wait_idle();

    // 5: start during RUN ignored; start+abort in IDLE stays IDLE
    do_start(3, t0);
    push_job(t0, 3, 3, 3, 1'b1);
    wait_until(t0 + 2);
    start = 1'b1; len = 5'd8;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    start = 1'b1; abort = 1'b1; len = 5'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t5_start_abort", {host_rd_ok, busy, aborted}, 3'b100);
    repeat (4) @(negedge clk);

    // 6: async reset mid-RUN, then a len=1 job
    do_start(8, t0);
    push_job(t0, 8, 3, 0, 1'b0);
    wait_until(t0 + 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_reset", {rd_en, wb_en, busy, done, host_rd_ok}, 5'b00001);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(1, t0);
    push_job(t0, 1, 1, 1, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("leftover_events", rd_q.size() + wb_q.size() + done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
